// File: rtl/key_command_decoder.sv
// rtl/key_command_decoder.sv - two-key command decoder: sync, debounce, short/long/chord press FSM
//   clk        in  1  sole clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   key        in  2  raw active-low push-buttons (0 = pressed), asynchronous to clk
//   save_mem   out 1  one-cycle pulse: short key[0] press released
//   clear_mem  out 1  one-cycle pulse: long key[0] hold, or key[0] pressed while key[1] held
//   read_mem   out 1  level: key[1] debounced-pressed
//   key0_state out 2  key[0] FSM state (00 IDLE, 01 HELD, 10 DONE)
module key_command_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key,
  output logic       save_mem,
  output logic       clear_mem,
  output logic       read_mem,
  output logic [1:0] key0_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          stable_q, stable_d;
  logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;
  logic                press0_q, press0_d;
  logic                release0_q, release0_d;
  logic                read_mem_q, read_mem_d;
  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                save_q, save_d;
  logic                clear_q, clear_d;

  // Synchronizers and debouncers
  always_comb begin
    sync1_d  = key;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      // Any agreeing cycle restarts the count; the DEBOUNCE_CYCLES-th
      // consecutive disagreeing cycle flips the stable level.
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = ~stable_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + CW'(1);
        end
      end
    end
    press0_d   = stable_q[0] & ~stable_d[0];
    release0_d = ~stable_q[0] & stable_d[0];
    // Built from the next stable level so read_mem tracks it with no lag.
    read_mem_d = ~stable_d[1];
  end

  // key[0] command FSM
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    save_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press0_q) begin
          if (!stable_q[1]) begin
            clear_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            hold_d  = '0;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
        // Reaching the long threshold wins over a coincident release.
        if (hold_q == HOLD_LAST) begin
          clear_d = 1'b1;
          state_d = ST_DONE;
        end else if (release0_q) begin
          save_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (release0_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      stable_q   <= 2'b11;
      db_cnt_q   <= '0;
      press0_q   <= 1'b0;
      release0_q <= 1'b0;
      read_mem_q <= 1'b0;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      save_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      press0_q   <= press0_d;
      release0_q <= release0_d;
      read_mem_q <= read_mem_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      save_q     <= save_d;
      clear_q    <= clear_d;
    end
  end

  assign save_mem   = save_q;
  assign clear_mem  = clear_q;
  assign read_mem   = read_mem_q;
  assign key0_state = state_q;

endmodule

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive cycles a synchronized key level must differ from its stable level before the stable level changes (minimum 2).
REQ-002 Parameter LONG_CYCLES, default 50000000, is the number of cycles a debounced key[0] press must be held to count as a long press (must exceed DEBOUNCE_CYCLES).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key  input  2  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-006 save_mem  output  1  one-cycle pulse: store the current result in memory.
REQ-007 clear_mem  output  1  one-cycle pulse: clear memory.
REQ-008 read_mem  output  1  level: show memory while key[1] is debounced-pressed.
REQ-009 key0_state  output  2  current key[0] FSM state, for debug (00 IDLE, 01 HELD, 10 DONE).

Function
REQ-010 Each key bit shall pass through a two-flop synchronizer, with both flops reset to 1.
REQ-011 Each key shall have its own debouncer with a counter and a stable level; the counter shall be cleared on any cycle where the synchronized level equals the stable level.
REQ-012 A debouncer shall toggle its stable level, and clear its counter, on the DEBOUNCE_CYCLES-th consecutive cycle of mismatch; the counter width shall hold DEBOUNCE_CYCLES without wrap.
REQ-013 Press event = stable level 1->0; release event = stable level 0->1; each event is valid for exactly one cycle.
REQ-014 read_mem shall equal the inverted key[1] stable level (registered, no extra latency).
REQ-015 The key[0] FSM shall have a hold counter that saturates at LONG_CYCLES.
REQ-016 FSM IDLE: on a key[0] press event with key[1] stable released, go to HELD and clear the hold counter.
REQ-017 FSM IDLE: on a key[0] press event with key[1] stable pressed (chord), pulse clear_mem in the next cycle and go to DONE.
REQ-018 FSM HELD: increment the hold counter every cycle.
REQ-019 FSM HELD: on a release event before the counter reaches LONG_CYCLES-1, pulse save_mem next cycle and go to IDLE.
REQ-020 FSM HELD: when the counter reaches LONG_CYCLES-1 with the key still pressed, pulse clear_mem next cycle and go to DONE; no save_mem shall follow.
REQ-021 FSM HELD: a release event in the same cycle the counter reaches LONG_CYCLES-1 shall count as long (clear_mem only).
REQ-022 FSM DONE: remain until a key[0] release event, then go to IDLE with no pulse.
REQ-023 save_mem and clear_mem shall be registered, mutually exclusive, and never high for two consecutive cycles.
REQ-024 Latency: press/release edge on the pin -> debounced event = 2 + DEBOUNCE_CYCLES cycles; event -> pulse = 1 cycle.
REQ-025 key[1] changes while in HELD shall not alter the FSM; only the press-time chord check applies.

Reset
REQ-026 When rst_n = 0, all of the following shall take effect immediately and asynchronously: synchronizers and stable levels = 1 (released), counters = 0, FSM = IDLE, save_mem = clear_mem = read_mem = 0, key0_state = 00.
REQ-027 Reset asserted mid-press shall abort the FSM with no pulse; after release of reset, a still-held key shall be seen as a new press only after debounce completes.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-028 Hold key[0]=0 for 10 cycles, then release -> exactly one save_mem pulse 7 cycles after the release pin edge; clear_mem stays 0.
REQ-029 Hold key[0]=0 for 40 cycles -> one clear_mem pulse; no save_mem on release; key0_state returns to 00 after release is debounced.
REQ-030 Toggle key[0] every 2 cycles for 30 cycles (bounce) -> no stable change and no pulses.
REQ-031 Hold key[1]=0, then press key[0] -> read_mem=1 and one clear_mem pulse; release both -> read_mem=0 and no save_mem.
REQ-032 Assert rst_n=0 while in HELD -> outputs 0 immediately, FSM at 00; keep key[0] held through reset release -> press re-detected after 6 cycles.
REQ-033 Release key[0] on exactly the 15th hold cycle -> clear_mem only (REQ-021 boundary).
